// File: rtl/sram_pkg.sv
// Shared types and constants for the two-port byte/bit-masked SRAM model.
package sram_pkg;

  // Controller state: clearing the array after reset, or serving accesses.
  typedef enum logic {
    SRAM_INIT  = 1'b0,
    SRAM_READY = 1'b1
  } sram_state_e;

  // Deepest read pipeline the model supports.
  localparam int MAX_LAT = 2;

  // Same-address read/write collision policies.
  localparam int POLICY_READ_FIRST  = 0;
  localparam int POLICY_WRITE_FIRST = 1;

endpackage

// File: rtl/sram_rd_pipe.sv
// Fixed-depth register chain carrying {valid, data} for the read port.
// Data stages only load when their valid input is set, so the last stage
// holds the most recently completed read.
module sram_rd_pipe #(
  parameter int W   = 128,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [LAT-1:0] vld;
  logic [W-1:0]   dat [LAT];

  // Shift valid every cycle; move data only alongside a valid token.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < LAT; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      if (in_valid) dat[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[LAT-1];
  assign out_data  = dat[LAT-1];

endmodule

// File: rtl/sram_1r1w_bw.sv
// Two-port (1 read, 1 write) SRAM model with per-bit active-low write mask,
// 1- or 2-cycle read latency, selectable collision policy and a post-reset
// clear engine that zeroes one word per cycle.
//
// Handshake: there is no backpressure. A read is accepted on any rising edge
// where RCEN=0 and the array is READY; its word is presented on Q with QV=1
// for exactly one cycle, Read_Latency edges after acceptance. A write is
// accepted on any rising edge where WCEN=0 and the array is READY.
module sram_1r1w_bw
  import sram_pkg::*;
#(
  parameter int Bits         = 128,
  parameter int Word_Depth   = 64,
  parameter int Add_Width    = $clog2(Word_Depth),
  parameter int Read_Latency = 1,
  parameter int Write_First  = 1,
  parameter int Init_Clear   = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 RCEN,
  input  logic [Add_Width-1:0] RA,
  output logic [Bits-1:0]      Q,
  output logic                 QV,
  input  logic                 WCEN,
  input  logic [Add_Width-1:0] WA,
  input  logic [Bits-1:0]      D,
  input  logic [Bits-1:0]      BWEN,
  output logic                 INIT_BUSY,
  output logic                 dbg_state
);

  if (Read_Latency < 1 || Read_Latency > MAX_LAT) begin : g_bad_latency
    $fatal(1, "sram_1r1w_bw: Read_Latency must be 1 or 2");
  end

  if (Word_Depth < 2) begin : g_bad_depth
    $fatal(1, "sram_1r1w_bw: Word_Depth must be at least 2");
  end

  localparam logic [Add_Width:0]   DEPTH_W   = (Add_Width + 1)'(Word_Depth);
  localparam logic [Add_Width-1:0] LAST_ADDR = Add_Width'(Word_Depth - 1);
  localparam sram_state_e          RESET_ST  = (Init_Clear != 0) ? SRAM_INIT : SRAM_READY;
  localparam logic                 RESET_BSY = (Init_Clear != 0);

  sram_state_e          state;
  logic [Add_Width-1:0] cnt;
  logic [Bits-1:0]      ram [Word_Depth];

  logic            ready;
  logic            ra_ok;
  logic            wa_ok;
  logic            rd_en;
  logic            wr_en;
  logic            collide;
  logic [Bits-1:0] wr_old;
  logic [Bits-1:0] wr_merge;
  logic [Bits-1:0] rd_old;
  logic [Bits-1:0] rd_data;

  // Clear engine: walk cnt over every word once, then park in READY.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= RESET_ST;
      cnt       <= '0;
      INIT_BUSY <= RESET_BSY;
    end else if (state == SRAM_INIT) begin
      if (cnt == LAST_ADDR) begin
        state     <= SRAM_READY;
        cnt       <= '0;
        INIT_BUSY <= 1'b0;
      end else begin
        cnt <= cnt + Add_Width'(1);
      end
    end
  end

  assign dbg_state = (state == SRAM_READY);

  // Out-of-range addresses are legal on the pins: writes drop, reads return 0.
  assign ready   = (state == SRAM_READY);
  assign ra_ok   = ({1'b0, RA} < DEPTH_W);
  assign wa_ok   = ({1'b0, WA} < DEPTH_W);
  assign rd_en   = ready & ~RCEN;
  assign wr_en   = ready & ~WCEN & wa_ok & RST_N;
  assign collide = rd_en & wr_en & (RA == WA);

  // Masked merge of new data into the currently stored word.
  always_comb begin
    wr_old = '0;
    if (wa_ok) wr_old = ram[WA];
    wr_merge = (D & ~BWEN) | (wr_old & BWEN);
  end

  // Read word selection, including the same-address collision policy.
  always_comb begin
    rd_old = '0;
    if (ra_ok) rd_old = ram[RA];
    rd_data = rd_old;
    if (collide && (Write_First == POLICY_WRITE_FIRST)) begin
      rd_data = (D & ~BWEN) | (rd_old & BWEN);
    end
  end

  // Single array write port shared by the clear engine and the write port.
  always_ff @(posedge CLK) begin
    if (state == SRAM_INIT) begin
      ram[cnt] <= '0;
    end else if (wr_en) begin
      ram[WA] <= wr_merge;
    end
  end

  sram_rd_pipe #(
    .W   (Bits),
    .LAT (Read_Latency)
  ) u_rd_pipe (
    .clk       (CLK),
    .rst_n     (RST_N),
    .in_valid  (rd_en),
    .in_data   (rd_data),
    .out_valid (QV),
    .out_data  (Q)
  );

endmodule

// File: tb/tb_sram_1r1w_bw.sv
// Bench for sram_1r1w_bw: two instances share one stimulus stream.
//   a: depth 64, latency 1, write-first
//   b: depth 48, latency 2, read-first (addresses 48..63 are out of range)
module tb_sram_1r1w_bw;

  localparam int W  = 128;
  localparam int AW = 6;

  // ---------------- clock / reset / pins ----------------
  logic          CLK = 1'b0;
  logic          RST_N;
  logic          RCEN, WCEN;
  logic [AW-1:0] RA, WA;
  logic [W-1:0]  D, BWEN;

  logic [W-1:0] q_a, q_b;
  logic         qv_a, qv_b, busy_a, busy_b, st_a, st_b;

  always #5 CLK = ~CLK;

  sram_1r1w_bw #(
    .Bits(W), .Word_Depth(64), .Read_Latency(1), .Write_First(1), .Init_Clear(1)
  ) dut_a (
    .CLK(CLK), .RST_N(RST_N), .RCEN(RCEN), .RA(RA), .Q(q_a), .QV(qv_a),
    .WCEN(WCEN), .WA(WA), .D(D), .BWEN(BWEN), .INIT_BUSY(busy_a), .dbg_state(st_a)
  );

  sram_1r1w_bw #(
    .Bits(W), .Word_Depth(48), .Read_Latency(2), .Write_First(0), .Init_Clear(1)
  ) dut_b (
    .CLK(CLK), .RST_N(RST_N), .RCEN(RCEN), .RA(RA), .Q(q_b), .QV(qv_b),
    .WCEN(WCEN), .WA(WA), .D(D), .BWEN(BWEN), .INIT_BUSY(busy_b), .dbg_state(st_b)
  );

  // ---------------- reference model ----------------
  int       depth [2] = '{64, 48};
  int       lat   [2] = '{1, 2};
  bit       wf    [2] = '{1'b1, 1'b0};
  logic [W-1:0] mem [2][64];
  bit       m_busy [2];
  int       m_cnt  [2];
  int       cyc;

  // Scoreboard: expected read words and the cycle each one must appear.
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  int           due_q_a[$];
  int           due_q_b[$];
  bit           exp_qv [2];
  logic [W-1:0] exp_qd [2];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b1;
      m_cnt[k]  = 0;
      exp_qv[k] = 1'b0;
      exp_qd[k] = '0;
    end
    exp_q_a.delete(); exp_q_b.delete();
    due_q_a.delete(); due_q_b.delete();
  endfunction

  // One rising edge of instance k, using the pins as they stand at the edge.
  function automatic void model_edge(input int k);
    logic [W-1:0] rd;
    if (m_busy[k]) begin
      mem[k][m_cnt[k]] = '0;
      m_cnt[k]++;
      if (m_cnt[k] == depth[k]) m_busy[k] = 1'b0;
    end else begin
      if (!RCEN) begin
        rd = (int'(RA) < depth[k]) ? mem[k][RA] : '0;
        if (wf[k] && !WCEN && (WA == RA) && (int'(WA) < depth[k]))
          rd = (D & ~BWEN) | (rd & BWEN);
        if (k == 0) begin exp_q_a.push_back(rd); due_q_a.push_back(cyc + lat[k] - 1); end
        else        begin exp_q_b.push_back(rd); due_q_b.push_back(cyc + lat[k] - 1); end
      end
      if (!WCEN && (int'(WA) < depth[k]))
        mem[k][WA] = (D & ~BWEN) | (mem[k][WA] & BWEN);
    end
    exp_qv[k] = 1'b0;
    if (k == 0) begin
      if (due_q_a.size() > 0 && due_q_a[0] == cyc) begin
        exp_qv[0] = 1'b1; exp_qd[0] = exp_q_a.pop_front(); void'(due_q_a.pop_front());
      end
    end else begin
      if (due_q_b.size() > 0 && due_q_b[0] == cyc) begin
        exp_qv[1] = 1'b1; exp_qd[1] = exp_q_b.pop_front(); void'(due_q_b.pop_front());
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one clock: model the edge, compare 1 ns later, return at negedge.
  task automatic cycle();
    @(posedge CLK);
    if (RST_N) begin
      cyc++;
      model_edge(0);
      model_edge(1);
    end
    #1;
    check("qv_a",   W'(qv_a),   W'(exp_qv[0]));
    check("q_a",    q_a,        exp_qd[0]);
    check("busy_a", W'(busy_a), W'(m_busy[0]));
    check("qv_b",   W'(qv_b),   W'(exp_qv[1]));
    check("q_b",    q_b,        exp_qd[1]);
    check("busy_b", W'(busy_b), W'(m_busy[1]));
    @(negedge CLK);
  endtask

  task automatic idle();
    RCEN = 1'b1;
    WCEN = 1'b1;
  endtask

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_ready();
    idle();
    for (int i = 0; i < 100 && (m_busy[0] || m_busy[1]); i++) cycle();
    check("init_done_a", W'(busy_a), '0);
    check("init_done_b", W'(busy_b), '0);
  endtask

  task automatic sweep_read();
    for (int a = 0; a < 64; a++) begin
      RCEN = 1'b0; WCEN = 1'b1; RA = AW'(a);
      cycle();
    end
    idle();
    repeat (3) cycle();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    RST_N = 1'b0; RCEN = 1'b1; WCEN = 1'b1;
    RA = '0; WA = '0; D = '0; BWEN = '1;
    cyc = 0;
    model_reset();

    @(negedge CLK); @(negedge CLK);
    check("rst_q_a",    q_a,        '0);
    check("rst_qv_a",   W'(qv_a),   '0);
    check("rst_busy_a", W'(busy_a), W'(1));
    check("rst_q_b",    q_b,        '0);
    check("rst_qv_b",   W'(qv_b),   '0);
    check("rst_busy_b", W'(busy_b), W'(1));

    // Accesses while clearing must be ignored.
    RST_N = 1'b1;
    for (int i = 0; i < 40; i++) begin
      RCEN = 1'($urandom_range(0, 1)); WCEN = 1'($urandom_range(0, 1));
      RA = AW'($urandom_range(0, 63)); WA = AW'($urandom_range(0, 63));
      D = rand_word(); BWEN = rand_word();
      cycle();
    end
    wait_ready();
    check("init_edges_a", W'(cyc), W'(64));
    sweep_read();

    // Masked write: only the low 16 bits land.
    WCEN = 1'b0; WA = 6'd5; D = '1; BWEN = {{(W-16){1'b1}}, 16'h0000};
    cycle();
    WCEN = 1'b1; RCEN = 1'b0; RA = 6'd5;
    cycle();
    idle(); repeat (3) cycle();
    check("mask_a", q_a, W'(16'hFFFF));
    check("mask_b", q_b, W'(16'hFFFF));

    // All-ones mask is a no-op.
    WCEN = 1'b0; WA = 6'd5; D = rand_word(); BWEN = '1;
    cycle();
    WCEN = 1'b1; RCEN = 1'b0; RA = 6'd5;
    cycle();
    idle(); repeat (3) cycle();
    check("noop_a", q_a, W'(16'hFFFF));
    check("noop_b", q_b, W'(16'hFFFF));

    // Collision on address 3.
    WCEN = 1'b0; WA = 6'd3; D = {16{8'hAA}}; BWEN = '0;
    cycle();
    RCEN = 1'b0; RA = 6'd3; WCEN = 1'b0; WA = 6'd3;
    D = {16{8'h55}}; BWEN = {{(W-8){1'b1}}, 8'h00};
    cycle();
    check("coll_wf1_a", q_a, {{15{8'hAA}}, 8'h55});
    idle();
    cycle();
    check("coll_wf0_b", q_b, {16{8'hAA}});
    RCEN = 1'b0; RA = 6'd3;
    cycle();
    idle(); repeat (2) cycle();
    check("coll_after_a", q_a, {{15{8'hAA}}, 8'h55});
    check("coll_after_b", q_b, {{15{8'hAA}}, 8'h55});

    // Streaming reads 0..9.
    for (int a = 0; a < 10; a++) begin
      RCEN = 1'b0; RA = AW'(a);
      cycle();
    end
    idle(); repeat (3) cycle();
    check("stream_tail_a", q_a, mem[0][9]);
    check("stream_tail_b", q_b, mem[1][9]);

    // Random traffic with frequent collisions and out-of-range addresses.
    for (int i = 0; i < 400; i++) begin
      RCEN = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
      WCEN = ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
      RA = AW'($urandom_range(0, 63));
      WA = ($urandom_range(0, 3) == 0) ? RA : AW'($urandom_range(0, 63));
      D = rand_word();
      case ($urandom_range(0, 3))
        0:       BWEN = '0;
        1:       BWEN = '1;
        default: BWEN = rand_word();
      endcase
      cycle();
    end
    idle(); repeat (3) cycle();

    // Reset with two reads in flight.
    RCEN = 1'b0; RA = AW'($urandom_range(0, 47));
    cycle();
    RA = AW'($urandom_range(0, 47));
    cycle();
    RCEN = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    model_reset();
    check("midrst_q_a",    q_a,        '0);
    check("midrst_qv_a",   W'(qv_a),   '0);
    check("midrst_busy_a", W'(busy_a), W'(1));
    check("midrst_q_b",    q_b,        '0);
    check("midrst_qv_b",   W'(qv_b),   '0);
    check("midrst_busy_b", W'(busy_b), W'(1));
    @(negedge CLK);
    cycle();
    RST_N = 1'b1;
    cyc = 0;
    wait_ready();
    check("reinit_edges", W'(cyc), W'(64));
    sweep_read();

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
